// File: rtl/router_pkg.sv
// Shared widths, state encoding and flag-select helper for the packet router
// write-side controller.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // Picks one per-FIFO flag; the invalid address reads as 0 (no FIFO there).
  function automatic logic sel_flag(logic [2:0] flags, logic [ADDR_W-1:0] a);
    case (a)
      2'd0:    sel_flag = flags[0];
      2'd1:    sel_flag = flags[1];
      2'd2:    sel_flag = flags[2];
      default: sel_flag = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Write-side packet router controller: decodes the header address, sequences
// header/payload/parity loads into the selected FIFO and handles full/timeout.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header with a valid address
// LOAD_FIRST_DATA    | header byte written to the selected FIFO
// LOAD_DATA          | payload bytes streaming into the FIFO
// LOAD_PARITY        | parity byte written
// FIFO_FULL_STATE    | FIFO full, source held off
// LOAD_AFTER_FULL    | write the byte latched while full, then resume
// WAIT_TILL_EMPTY    | target FIFO still draining a previous packet
// CHECK_PARITY_ERROR | clear internal parity register, packet done
module router_fsm
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] din,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic              fifo_full,
  input  logic              fifo_empty0,
  input  logic              fifo_empty1,
  input  logic              fifo_empty2,
  input  logic              soft_reset0,
  input  logic              soft_reset1,
  input  logic              soft_reset2,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [2:0]        fifo_empty, soft_reset;
  logic              empty_din, empty_addr, soft_rst_sel;

  assign fifo_empty   = {fifo_empty2, fifo_empty1, fifo_empty0};
  assign soft_reset   = {soft_reset2, soft_reset1, soft_reset0};
  assign empty_din    = sel_flag(fifo_empty, din);
  assign empty_addr   = sel_flag(fifo_empty, addr);
  assign soft_rst_sel = sel_flag(soft_reset, addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DECODE_ADDRESS;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    if (state == DECODE_ADDRESS && pkt_valid)
      addr_nxt = din;
    if (soft_rst_sel) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (pkt_valid && din != ADDR_INVALID)
            state_nxt = empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (empty_addr) state_nxt = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          state_nxt = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) state_nxt = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        state_nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) state_nxt = LOAD_PARITY;
          else                    state_nxt = LOAD_DATA;
        LOAD_PARITY:
          state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:
          state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  // Pure state decode so no input reaches an output combinationally.
  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                    (state == LOAD_AFTER_FULL);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: expected output vectors are queued as each
// step is driven and popped for comparison after the clock edge.
module tb_router_fsm;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [1:0] din;
  logic       fifo_empty0, fifo_empty1, fifo_empty2;
  logic       soft_reset0, soft_reset1, soft_reset2;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  router_fsm dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .fifo_full(fifo_full), .fifo_empty0(fifo_empty0),
    .fifo_empty1(fifo_empty1), .fifo_empty2(fifo_empty2),
    .soft_reset0(soft_reset0), .soft_reset1(soft_reset1),
    .soft_reset2(soft_reset2), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  // {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy}
  function automatic logic [7:0] exp_vec(state_t s);
    case (s)
      DECODE_ADDRESS:     exp_vec = 8'b1000_0000;
      LOAD_FIRST_DATA:    exp_vec = 8'b0100_0001;
      LOAD_DATA:          exp_vec = 8'b0010_0100;
      LOAD_PARITY:        exp_vec = 8'b0000_0101;
      FIFO_FULL_STATE:    exp_vec = 8'b0000_1001;
      LOAD_AFTER_FULL:    exp_vec = 8'b0001_0101;
      WAIT_TILL_EMPTY:    exp_vec = 8'b0000_0001;
      CHECK_PARITY_ERROR: exp_vec = 8'b0000_0011;
      default:            exp_vec = 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] obs_vec();
    obs_vec = {detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy};
  endfunction

  task automatic expect_push(input state_t s, input string tag);
    exp_q.push_back(exp_vec(s));
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    logic [7:0] e;
    logic [7:0] o;
    string      t;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_underflow: observed empty queue required an entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = obs_vec();
      assert (o === e) else begin
        n_bad++;
        $error("FAIL %s: observed %b required %b", t, o, e);
      end
    end
  endtask

  // One clock: queue the expected post-edge state, clock, then compare.
  task automatic step(input state_t s, input string tag);
    expect_push(s, tag);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    rst = 1'b0; pkt_valid = 1'b0; din = 2'd0; parity_done = 1'b0;
    low_pkt_valid = 1'b0; fifo_full = 1'b0;
    fifo_empty0 = 1'b1; fifo_empty1 = 1'b1; fifo_empty2 = 1'b1;
    soft_reset0 = 1'b0; soft_reset1 = 1'b0; soft_reset2 = 1'b0;

    expect_push(DECODE_ADDRESS, "reset_initial");
    #2; check_pop();
    step(DECODE_ADDRESS, "reset_held");
    rst = 1'b1;

    // Invalid address: header with din=3 never leaves decode
    pkt_valid = 1'b1; din = 2'd3;
    step(DECODE_ADDRESS, "din3_a");
    step(DECODE_ADDRESS, "din3_b");
    pkt_valid = 1'b0;
    step(DECODE_ADDRESS, "idle");

    // Normal packet to FIFO 1
    pkt_valid = 1'b1; din = 2'd1;
    step(LOAD_FIRST_DATA, "pkt1_lfd");
    din = 2'd0;
    step(LOAD_DATA, "pkt1_ld1");
    step(LOAD_DATA, "pkt1_ld2");
    step(LOAD_DATA, "pkt1_ld3");
    pkt_valid = 1'b0;
    step(LOAD_PARITY, "pkt1_lp");
    step(CHECK_PARITY_ERROR, "pkt1_cpe");
    step(DECODE_ADDRESS, "pkt1_done");

    // FIFO 2 busy for 5 cycles
    pkt_valid = 1'b1; din = 2'd2; fifo_empty2 = 1'b0;
    step(WAIT_TILL_EMPTY, "wte_1");
    din = 2'd0;
    step(WAIT_TILL_EMPTY, "wte_2");
    step(WAIT_TILL_EMPTY, "wte_3");
    step(WAIT_TILL_EMPTY, "wte_4");
    step(WAIT_TILL_EMPTY, "wte_5");
    fifo_empty2 = 1'b1;
    step(LOAD_FIRST_DATA, "wte_lfd");

    // FIFO fills mid-payload
    step(LOAD_DATA, "full_ld");
    fifo_full = 1'b1;
    step(FIFO_FULL_STATE, "full_1");
    step(FIFO_FULL_STATE, "full_2");
    step(FIFO_FULL_STATE, "full_3");
    step(FIFO_FULL_STATE, "full_4");
    fifo_full = 1'b0; low_pkt_valid = 1'b1; parity_done = 1'b0;
    step(LOAD_AFTER_FULL, "full_laf");
    step(LOAD_PARITY, "full_lp");
    fifo_full = 1'b1;
    step(CHECK_PARITY_ERROR, "full_cpe");
    step(FIFO_FULL_STATE, "cpe_to_full");
    fifo_full = 1'b0; parity_done = 1'b1;
    step(LOAD_AFTER_FULL, "laf2");
    step(DECODE_ADDRESS, "laf_parity_done");
    parity_done = 1'b0; low_pkt_valid = 1'b0; pkt_valid = 1'b0;

    // Soft reset of a non-addressed FIFO is ignored
    pkt_valid = 1'b1; din = 2'd0; fifo_empty0 = 1'b0;
    step(WAIT_TILL_EMPTY, "sr_wte");
    soft_reset1 = 1'b1;
    step(WAIT_TILL_EMPTY, "sr1_ignored");
    soft_reset1 = 1'b0; soft_reset0 = 1'b1;
    step(DECODE_ADDRESS, "sr0_taken");
    soft_reset0 = 1'b0; pkt_valid = 1'b0;
    step(DECODE_ADDRESS, "sr_idle");

    // LOAD_AFTER_FULL back to LOAD_DATA, then soft reset overrides full
    fifo_empty0 = 1'b1; pkt_valid = 1'b1; din = 2'd0;
    step(LOAD_FIRST_DATA, "laf_lfd");
    step(LOAD_DATA, "laf_ld");
    fifo_full = 1'b1;
    step(FIFO_FULL_STATE, "laf_full");
    fifo_full = 1'b0;
    step(LOAD_AFTER_FULL, "laf3");
    step(LOAD_DATA, "laf_to_ld");
    fifo_full = 1'b1; soft_reset0 = 1'b1;
    step(DECODE_ADDRESS, "sr_over_full");
    fifo_full = 1'b0; soft_reset0 = 1'b0; pkt_valid = 1'b0;

    // Asynchronous reset in the middle of LOAD_DATA
    pkt_valid = 1'b1; din = 2'd1;
    step(LOAD_FIRST_DATA, "rst_lfd");
    step(LOAD_DATA, "rst_ld");
    expect_push(DECODE_ADDRESS, "rst_async");
    rst = 1'b0;
    #1; check_pop();
    step(DECODE_ADDRESS, "rst_hold");
    rst = 1'b1; pkt_valid = 1'b0;
    step(DECODE_ADDRESS, "rst_release");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 The block SHALL have no parameters; widths and state codes come from router_pkg.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 pkt_valid  input  1  source packet-valid; high for header and payload bytes, low at the parity byte.
REQ-005 din  input  2  header address bits [1:0]; 0..2 select FIFO 0..2, 3 is invalid.
REQ-006 parity_done  input  1  register block has captured the parity byte.
REQ-007 low_pkt_valid  input  1  register block saw pkt_valid fall while the FIFO was full.
REQ-008 fifo_full  input  1  full flag of the currently addressed FIFO, from the synchronizer.
REQ-009 fifo_empty0, fifo_empty1, fifo_empty2  input  1 each  per-FIFO empty flags.
REQ-010 soft_reset0, soft_reset1, soft_reset2  input  1 each  per-FIFO 30-cycle timeout flags from the synchronizer.
REQ-011 detect_add  output  1  high in DECODE_ADDRESS; drives the synchronizer address capture.
REQ-012 lfd_state  output  1  high in LOAD_FIRST_DATA (header write).
REQ-013 ld_state  output  1  high in LOAD_DATA.
REQ-014 laf_state  output  1  high in LOAD_AFTER_FULL.
REQ-015 full_state  output  1  high in FIFO_FULL_STATE.
REQ-016 write_enb_reg  output  1  high in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
REQ-017 rst_int_reg  output  1  high in CHECK_PARITY_ERROR; clears the internal parity register.
REQ-018 busy  output  1  back-pressure to source; low only in DECODE_ADDRESS and LOAD_DATA.

Function
REQ-019 All outputs SHALL be Moore decodes of the state register only; no combinational path from any input to any output.
REQ-020 States SHALL be DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
REQ-021 A 2-bit addr register SHALL load din on any clock edge where state is DECODE_ADDRESS and pkt_valid=1; it holds otherwise.
REQ-022 DECODE_ADDRESS: pkt_valid=1, din!=3, fifo_empty[din]=1 -> LOAD_FIRST_DATA; pkt_valid=1, din!=3, fifo_empty[din]=0 -> WAIT_TILL_EMPTY; otherwise (including din=3) stay.
REQ-023 WAIT_TILL_EMPTY: fifo_empty[addr]=1 -> LOAD_FIRST_DATA; else stay.
REQ-024 LOAD_FIRST_DATA -> LOAD_DATA unconditionally after exactly one cycle.
REQ-025 LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE (priority); else pkt_valid=0 -> LOAD_PARITY; else stay.
REQ-026 FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
REQ-027 LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_pkt_valid=1 -> LOAD_PARITY; else LOAD_DATA.
REQ-028 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-029 CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else DECODE_ADDRESS.
REQ-030 soft_reset[addr]=1 SHALL force DECODE_ADDRESS on the next edge from any state, overriding REQ-022..029; soft_reset of a non-addressed FIFO SHALL be ignored.
REQ-031 addr=3 SHALL never be loaded into any non-DECODE state path; soft_reset/fifo_empty indexing with addr=3 is unreachable and SHALL default to stay/ignore.

Reset
REQ-032 rst=0 SHALL asynchronously force state=DECODE_ADDRESS and addr=0, giving detect_add=1 and all other outputs 0 (busy=0), including mid-packet; first transition occurs on the first rising edge after rst=1.

Structure
REQ-033 router_pkg SHALL hold the state enum (3-bit, binary encoded), ADDR_W=2 and ADDR_INVALID=2'b11; no sub-module, single always_ff state/addr register plus combinational next-state and output decode.

Verification
REQ-034 Reset mid-LOAD_DATA: drop rst -> same-cycle detect_add=1, write_enb_reg=0, busy=0.
REQ-035 Normal packet din=1, fifo_empty1=1, 3 payload cycles then pkt_valid=0 -> states DECODE,LFD,LD x3,LOAD_PARITY,CHECK_PARITY_ERROR,DECODE; rst_int_reg high one cycle.
REQ-036 din=2 with fifo_empty2=0 for 5 cycles then 1 -> WAIT_TILL_EMPTY 5 cycles with busy=1, then LOAD_FIRST_DATA.
REQ-037 fifo_full=1 during LD for 4 cycles, then 0 with low_pkt_valid=1, parity_done=0 -> FIFO_FULL_STATE x4, LOAD_AFTER_FULL, LOAD_PARITY.
REQ-038 din=3 with pkt_valid=1 -> stays DECODE_ADDRESS, no write_enb_reg.
REQ-039 addr=0 in WAIT_TILL_EMPTY, soft_reset1=1 then soft_reset0=1 -> ignored, then DECODE_ADDRESS next edge.
